// File: rtl/gsu_cache_fill_if.sv
// Bundles the cache-fill unit's core fetch handshake, external read bus and SNES cache-window port.
interface gsu_cache_fill_if #(
  parameter int MEM_AW = 24
);
  logic              fetch_req;
  logic [15:0]       pc;
  logic [7:0]        pbr;
  logic [15:0]       cbr;
  logic              flush;
  logic              fetch_busy;
  logic              fetch_valid;
  logic [7:0]        fetch_data;
  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic              cpu_we;
  logic [8:0]        cpu_addr;
  logic [7:0]        cpu_di;
  logic [7:0]        cpu_do;

  modport slave (
    input  fetch_req, pc, pbr, cbr, flush, mem_ack, mem_data, cpu_we, cpu_addr, cpu_di,
    output fetch_busy, fetch_valid, fetch_data, mem_req, mem_addr, cpu_do
  );

  modport master (
    output fetch_req, pc, pbr, cbr, flush, mem_ack, mem_data, cpu_we, cpu_addr, cpu_di,
    input  fetch_busy, fetch_valid, fetch_data, mem_req, mem_addr, cpu_do
  );
endinterface

// File: rtl/gsu_cache_fill.sv
// GSU instruction fetch / code-cache fill unit: 512-byte cache with 32 line-valid flags,
// whole-line fills and uncached direct reads over the external bus, plus the SNES cache window.
module gsu_cache_fill #(
  parameter int LINE_W = 4,
  parameter int MEM_AW = 24
) (
  input logic             clkin,
  input logic             rst_n,
  gsu_cache_fill_if.slave bus
);
  localparam int IDX_W = 9;
  localparam int LINES = 1 << (IDX_W - LINE_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FILL_REQ, S_FILL_WAIT, S_DIRECT_REQ, S_DIRECT_WAIT, S_RESPOND
  } state_e;

  state_e                    state_q, state_d;
  logic [15:0]               pc_q, cbr_q;
  logic [7:0]                pbr_q;
  logic [LINE_W-1:0]         i_q;
  logic [LINES-1:0]          flag_q;
  logic                      abort_q;
  logic [7:0]                cache [1 << IDX_W];

  logic [15:0]               off, fill_lo;
  logic                      in_win;
  logic [IDX_W-1:0]          idx, fill_idx;
  logic [IDX_W-LINE_W-1:0]   line;
  logic                      accept, cpu_wr, fill_ack, abort_now, fill_done, direct_ack;

  // Window offset from the line-aligned cache base; everything wraps at 16 bits.
  assign off      = pc_q - (cbr_q & 16'hFFF0);
  assign in_win   = (off[15:IDX_W] == '0);
  assign idx      = off[IDX_W-1:0];
  assign line     = idx[IDX_W-1:LINE_W];
  assign fill_idx = {line, i_q};
  assign fill_lo  = (cbr_q & 16'hFFF0) + {7'd0, fill_idx};

  assign accept     = (state_q == S_IDLE) && bus.fetch_req;
  assign cpu_wr     = (state_q == S_IDLE) && bus.cpu_we;
  assign fill_ack   = (state_q == S_FILL_WAIT) && bus.mem_ack;
  assign abort_now  = abort_q || bus.flush;
  assign fill_done  = fill_ack && !abort_now && (i_q == '1);
  assign direct_ack = (state_q == S_DIRECT_WAIT) && bus.mem_ack;

  // NOTE: clocked blocks use only <=, so every register sees pre-edge values whatever the block order.
  always_ff @(posedge clkin) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: all outputs of this block get a default before the case, so no path can infer a latch.
  always_comb begin
    state_d         = state_q;
    bus.fetch_busy  = (state_q != S_IDLE);
    bus.fetch_valid = 1'b0;
    unique case (state_q)
      S_IDLE:        if (bus.fetch_req) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (!in_win)           state_d = S_DIRECT_REQ;
        else if (flag_q[line]) state_d = S_RESPOND;
        else                   state_d = S_FILL_REQ;
      end
      S_FILL_REQ:    state_d = S_FILL_WAIT;
      S_FILL_WAIT: begin
        if (bus.mem_ack) begin
          if (abort_now)       state_d = S_IDLE;
          else if (i_q == '1)  state_d = S_RESPOND;
          else                 state_d = S_FILL_REQ;
        end
      end
      S_DIRECT_REQ:  state_d = S_DIRECT_WAIT;
      S_DIRECT_WAIT: if (bus.mem_ack) state_d = S_RESPOND;
      S_RESPOND: begin
        bus.fetch_valid = 1'b1;
        state_d         = S_IDLE;
      end
      default:       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      pc_q           <= '0;
      cbr_q          <= '0;
      pbr_q          <= '0;
      i_q            <= '0;
      flag_q         <= '0;
      abort_q        <= 1'b0;
      bus.fetch_data <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.cpu_do     <= '0;
    end else begin
      if (accept) begin
        pc_q  <= bus.pc;
        pbr_q <= bus.pbr;
        cbr_q <= bus.cbr;
      end

      if (state_q == S_LOOKUP) i_q <= '0;
      else if (fill_ack)       i_q <= i_q + 1'b1;

      // A flush seen mid-fill lets the outstanding read finish, then drops the line.
      if (state_q == S_IDLE)
        abort_q <= 1'b0;
      else if (bus.flush && (state_q == S_FILL_REQ || state_q == S_FILL_WAIT))
        abort_q <= 1'b1;

      if (bus.flush) begin
        flag_q <= '0;
      end else begin
        if (cpu_wr && bus.cpu_addr[LINE_W-1:0] == '1) flag_q[bus.cpu_addr[IDX_W-1:LINE_W]] <= 1'b1;
        if (fill_done) flag_q[line] <= 1'b1;
      end

      if (state_q == S_FILL_REQ) begin
        bus.mem_req  <= 1'b1;
        bus.mem_addr <= MEM_AW'({pbr_q, fill_lo});
      end else if (state_q == S_DIRECT_REQ) begin
        bus.mem_req  <= 1'b1;
        bus.mem_addr <= MEM_AW'({pbr_q, pc_q});
      end else if (bus.mem_ack) begin
        bus.mem_req  <= 1'b0;
      end

      // The last beat of a fill is written this same edge, so it bypasses the array.
      if (state_q == S_LOOKUP && in_win && flag_q[line])
        bus.fetch_data <= cache[idx];
      else if (fill_done)
        bus.fetch_data <= (idx[LINE_W-1:0] == '1) ? bus.mem_data : cache[idx];
      else if (direct_ack)
        bus.fetch_data <= bus.mem_data;

      bus.cpu_do <= cache[bus.cpu_addr];
    end
  end

  // NOTE: the cache array has no reset so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge clkin) begin
    if (rst_n) begin
      if (cpu_wr)        cache[bus.cpu_addr] <= bus.cpu_di;
      else if (fill_ack) cache[fill_idx]     <= bus.mem_data;
    end
  end
endmodule

// File: tb/tb_gsu_cache_fill.sv
// Self-checking bench for gsu_cache_fill: fetch vector table, fetch/bus scoreboards, flush and busy corner cases.
module tb_gsu_cache_fill;
  logic clkin = 1'b0;
  logic rst_n = 1'b0;
  always #5 clkin = ~clkin;

  gsu_cache_fill_if bus_if ();
  gsu_cache_fill dut (.clkin(clkin), .rst_n(rst_n), .bus(bus_if));

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  pbr;
    logic [15:0] cbr;
    logic [7:0]  data;
    int          nreads;
    int          lat;
  } fetch_vec_t;

  int          errors = 0, checks = 0;
  int          cyc = 0, valids = 0, reads = 0;
  int          valid_cyc = 0, drive_cyc = 0, base_valids = 0, base_reads = 0;
  logic [7:0]  fetch_q [$];
  logic [23:0] addr_q  [$];

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Fetch monitor: every fetch_valid pulse pops one expected byte.
  initial begin
    forever begin
      @(negedge clkin);
      if (rst_n && bus_if.fetch_valid) begin
        valids++;
        valid_cyc = cyc;
        if (fetch_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: data 0x%0h with nothing expected", bus_if.fetch_data);
        end else begin
          check("fetch_data", 32'(bus_if.fetch_data), 32'(fetch_q.pop_front()));
        end
      end
    end
  end

  // Bus responder: acks two cycles after a request with data = addr[7:0], checking each address.
  initial begin
    logic [23:0] a;
    bus_if.mem_ack  = 1'b0;
    bus_if.mem_data = 8'h00;
    forever begin
      @(negedge clkin);
      if (rst_n && bus_if.mem_req) begin
        a = bus_if.mem_addr;
        reads++;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: addr 0x%0h", a);
        end else begin
          check("mem_addr", 32'(a), 32'(addr_q.pop_front()));
        end
        @(negedge clkin);
        bus_if.mem_ack  = 1'b1;
        bus_if.mem_data = a[7:0];
        @(negedge clkin);
        bus_if.mem_ack  = 1'b0;
      end
    end
  end

  task automatic cpu_write(input logic [8:0] addr, input logic [7:0] data);
    @(negedge clkin);
    bus_if.cpu_we = 1'b1; bus_if.cpu_addr = addr; bus_if.cpu_di = data;
    @(negedge clkin);
    bus_if.cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [8:0] addr, input logic [7:0] exp);
    @(negedge clkin);
    bus_if.cpu_addr = addr;
    @(negedge clkin);
    check("cpu_do", 32'(bus_if.cpu_do), 32'(exp));
  endtask

  task automatic start_fetch(input logic [15:0] pc, input logic [7:0] pbr, input logic [15:0] cbr,
                             input logic [7:0] exp_data, input int nreads, input bit want_valid,
                             input bit we, input logic [8:0] waddr, input logic [7:0] wdata);
    logic [15:0] lo;
    @(negedge clkin);
    base_valids = valids;
    base_reads  = reads;
    drive_cyc   = cyc;
    if (want_valid) fetch_q.push_back(exp_data);
    if (nreads == 1) addr_q.push_back({pbr, pc});
    else begin
      for (int i = 0; i < nreads; i++) begin
        lo = (pc & 16'hFFF0) + 16'(i);
        addr_q.push_back({pbr, lo});
      end
    end
    bus_if.fetch_req = 1'b1; bus_if.pc = pc; bus_if.pbr = pbr; bus_if.cbr = cbr;
    bus_if.cpu_we = we; bus_if.cpu_addr = waddr; bus_if.cpu_di = wdata;
    @(posedge clkin);
    #1;
    // Scramble the request inputs: the unit must work from its latched copy.
    bus_if.fetch_req = 1'b0; bus_if.cpu_we = 1'b0;
    bus_if.pc = 16'($urandom); bus_if.pbr = 8'($urandom); bus_if.cbr = 16'($urandom);
  endtask

  task automatic finish_fetch(input bit want_valid, input int nreads, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clkin);
      n++;
    end while (bus_if.fetch_busy && n < 400);
    if (bus_if.fetch_busy) begin
      checks++; errors++;
      $display("FAIL fetch_timeout: still busy after %0d cycles", n);
    end
    check("valid_count", 32'(valids - base_valids), 32'(want_valid));
    check("read_count", 32'(reads - base_reads), 32'(nreads));
    if (want_valid && exp_lat > 0) check("hit_latency", 32'(valid_cyc - drive_cyc), 32'(exp_lat));
    fetch_q.delete();
    addr_q.delete();
  endtask

  // Returns at the point where the n-th ack is being presented (before its sampling edge).
  task automatic wait_acks(input int n);
    int seen, t;
    seen = 0; t = 0;
    while (seen < n && t < 500) begin
      @(negedge clkin);
      #1;
      t++;
      if (bus_if.mem_ack) seen++;
    end
    if (seen < n) begin
      checks++; errors++;
      $display("FAIL ack_timeout: saw %0d of %0d acks", seen, n);
    end
  endtask

  initial begin
    fetch_vec_t vecs [12];
    vecs[0]  = '{16'h8003, 8'h01, 16'h8000, 8'hA5, 0,  2};  // preloaded hit
    vecs[1]  = '{16'h800F, 8'h01, 16'h8007, 8'h4F, 0,  2};  // cbr[3:0] ignored
    vecs[2]  = '{16'h8027, 8'h01, 16'h8000, 8'h27, 16, 0};  // miss, line 2
    vecs[3]  = '{16'h802A, 8'h01, 16'h8000, 8'h2A, 0,  2};  // now a hit
    vecs[4]  = '{16'h0005, 8'h01, 16'hFFF0, 8'h05, 16, 0};  // wrapped base, line 1
    vecs[5]  = '{16'h000C, 8'h01, 16'hFFF7, 8'h0C, 0,  2};
    vecs[6]  = '{16'h8200, 8'h01, 16'h8000, 8'h00, 1,  0};  // first byte past window
    vecs[7]  = '{16'h8200, 8'h01, 16'h8000, 8'h00, 1,  0};  // never cached
    vecs[8]  = '{16'h81FF, 8'h01, 16'h8000, 8'hFF, 16, 0};  // last byte of last line
    vecs[9]  = '{16'h7FFF, 8'h01, 16'h8000, 8'hFF, 1,  0};  // below base
    vecs[10] = '{16'h9033, 8'h7E, 16'h9000, 8'h33, 16, 0};
    vecs[11] = '{16'h9034, 8'h7E, 16'h9000, 8'h34, 0,  2};

    bus_if.fetch_req = 1'b0; bus_if.pc = '0; bus_if.pbr = '0; bus_if.cbr = '0; bus_if.flush = 1'b0;
    bus_if.cpu_we = 1'b0; bus_if.cpu_addr = '0; bus_if.cpu_di = '0;

    repeat (3) @(negedge clkin);
    check("rst_fetch_busy", 32'(bus_if.fetch_busy), 32'(0));
    check("rst_fetch_valid", 32'(bus_if.fetch_valid), 32'(0));
    check("rst_fetch_data", 32'(bus_if.fetch_data), 32'(0));
    check("rst_mem_req", 32'(bus_if.mem_req), 32'(0));
    check("rst_mem_addr", 32'(bus_if.mem_addr), 32'(0));
    check("rst_cpu_do", 32'(bus_if.cpu_do), 32'(0));
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) cpu_write(9'(k), (k == 3) ? 8'hA5 : 8'(8'h40 + k));
    cpu_read(9'h003, 8'hA5);
    cpu_read(9'h000, 8'h40);
    cpu_read(9'h00F, 8'h4F);

    foreach (vecs[v]) begin
      start_fetch(vecs[v].pc, vecs[v].pbr, vecs[v].cbr, vecs[v].data, vecs[v].nreads,
                  1'b1, 1'b0, 9'h000, 8'h00);
      finish_fetch(1'b1, vecs[v].nreads, vecs[v].lat);
    end

    // SNES write and fetch request in the same IDLE cycle: lookup sees the new byte and flag.
    start_fetch(16'h807F, 8'h01, 16'h8000, 8'h99, 0, 1'b1, 1'b1, 9'h07F, 8'h99);
    finish_fetch(1'b1, 0, 2);

    // Flush after the 5th ack: the 6th read completes, no response, all flags cleared.
    start_fetch(16'h8045, 8'h01, 16'h8000, 8'h00, 6, 1'b0, 1'b0, 9'h000, 8'h00);
    wait_acks(5);
    @(negedge clkin); #1; bus_if.flush = 1'b1;
    @(negedge clkin); #1; bus_if.flush = 1'b0;
    finish_fetch(1'b0, 6, 0);
    start_fetch(16'h8003, 8'h01, 16'h8000, 8'h03, 16, 1'b1, 1'b0, 9'h000, 8'h00);
    finish_fetch(1'b1, 16, 0);
    start_fetch(16'h8045, 8'h01, 16'h8000, 8'h45, 16, 1'b1, 1'b0, 9'h000, 8'h00);
    finish_fetch(1'b1, 16, 0);

    // Flush together with the final ack: flag must stay clear, so the refetch refills.
    start_fetch(16'h8055, 8'h01, 16'h8000, 8'h00, 16, 1'b0, 1'b0, 9'h000, 8'h00);
    wait_acks(16);
    bus_if.flush = 1'b1;
    @(negedge clkin); #1; bus_if.flush = 1'b0;
    finish_fetch(1'b0, 16, 0);
    start_fetch(16'h8055, 8'h01, 16'h8000, 8'h55, 16, 1'b1, 1'b0, 9'h000, 8'h00);
    finish_fetch(1'b1, 16, 0);

    // SNES writes while busy are dropped: neither data nor flag changes.
    start_fetch(16'h8065, 8'h01, 16'h8000, 8'h65, 16, 1'b1, 1'b0, 9'h000, 8'h00);
    repeat (6) @(negedge clkin);
    bus_if.cpu_we = 1'b1; bus_if.cpu_addr = 9'h003; bus_if.cpu_di = 8'hEE;
    check("busy_during_guard", 32'(bus_if.fetch_busy), 32'(1));
    @(negedge clkin);
    bus_if.cpu_addr = 9'h0EF; bus_if.cpu_di = 8'h77;
    @(negedge clkin);
    bus_if.cpu_we = 1'b0;
    finish_fetch(1'b1, 16, 0);
    cpu_read(9'h003, 8'h03);
    start_fetch(16'h80EF, 8'h01, 16'h8000, 8'hEF, 16, 1'b1, 1'b0, 9'h000, 8'h00);
    finish_fetch(1'b1, 16, 0);
    cpu_read(9'h0EF, 8'hEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
